// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor gate driver: coil select encoding,
// PWM geometry, dead-time FSM states and the coil-select to gate-request decode.
package mtr_pkg;

  typedef enum logic [1:0] {
    HIGH_Z    = 2'b00,
    REV_CURR  = 2'b01,
    FRWD_CURR = 2'b10,
    BRAKING   = 2'b11
  } coil_sel_t;

  typedef enum logic {
    HOLD_OFF = 1'b0,
    PASS     = 1'b1
  } dt_state_t;

  localparam int PWM_W      = 11;
  localparam int PWM_PERIOD = 2048;

  // Returns the requested {high, low} gate pair for one phase.
  function automatic logic [1:0] gate_req(input coil_sel_t sel, input logic pwm);
    case (sel)
      FRWD_CURR: gate_req = {pwm, ~pwm};
      REV_CURR:  gate_req = {~pwm, pwm};
      BRAKING:   gate_req = {1'b0, pwm};
      default:   gate_req = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/nonoverlap.sv
// Per-phase dead-time inserter: any change in the requested gate pair forces both
// FETs off for DEAD_TIME cycles before the new request is passed through.
module nonoverlap
  import mtr_pkg::*;
#(
  parameter int DEAD_TIME = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic highIn,
  input  logic lowIn,
  output logic highOut,
  output logic lowOut
);

  localparam logic [7:0] DCNT_LAST = 8'(DEAD_TIME - 1);

  dt_state_t  state, state_next;
  logic [7:0] dcnt, dcnt_next;
  logic [1:0] req, req_q;
  logic       changed, gate_en;
  logic       high_next, low_next;

  assign req     = {highIn, lowIn};
  assign changed = (req != req_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOLD_OFF;
      dcnt    <= '0;
      req_q   <= '0;
      highOut <= 1'b0;
      lowOut  <= 1'b0;
    end else begin
      state   <= state_next;
      dcnt    <= dcnt_next;
      req_q   <= req;
      highOut <= high_next;
      lowOut  <= low_next;
    end
  end

  // The cycle that completes the hold window already passes the request, so the
  // outputs are dark for exactly DEAD_TIME cycles after a change.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    gate_en    = 1'b0;
    if (changed) begin
      state_next = HOLD_OFF;
      dcnt_next  = '0;
    end else if (state == HOLD_OFF) begin
      if (dcnt == DCNT_LAST) begin
        state_next = PASS;
        gate_en    = 1'b1;
      end else begin
        dcnt_next = dcnt + 8'd1;
      end
    end else begin
      gate_en = 1'b1;
    end
    // An illegal hi=lo=1 request never reaches the FETs.
    high_next = gate_en & highIn & ~lowIn;
    low_next  = gate_en & lowIn & ~highIn;
  end

endmodule

// File: rtl/mtr_drv.sv
// Motor power-stage driver: 2048-cycle PWM with period-aligned duty latch,
// per-phase coil-select decode and dead-time protected gate outputs.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter int DEAD_TIME = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty,
  input  logic [1:0]       selGrn,
  input  logic [1:0]       selYlw,
  input  logic [1:0]       selBlu,
  output logic             PWM_synch,
  output logic             highGrn,
  output logic             lowGrn,
  output logic             highYlw,
  output logic             lowYlw,
  output logic             highBlu,
  output logic             lowBlu
);

  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0] cnt, cnt_next;
  logic [PWM_W-1:0] duty_q, duty_q_next;
  logic             pwm_sig;
  logic [1:0]       req_grn, req_ylw, req_blu;

  assign cnt_next    = cnt + PWM_W'(1);
  assign duty_q_next = (cnt == CNT_LAST) ? duty : duty_q;

  // PWM_sig and PWM_synch are computed from next-state values so they line up
  // with the counter value they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      duty_q    <= '0;
      pwm_sig   <= 1'b0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      duty_q    <= duty_q_next;
      pwm_sig   <= (cnt_next < duty_q_next);
      PWM_synch <= (cnt_next == '0);
    end
  end

  assign req_grn = gate_req(coil_sel_t'(selGrn), pwm_sig);
  assign req_ylw = gate_req(coil_sel_t'(selYlw), pwm_sig);
  assign req_blu = gate_req(coil_sel_t'(selBlu), pwm_sig);

  nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_grn (
    .clk    (clk),
    .rst    (rst),
    .highIn (req_grn[1]),
    .lowIn  (req_grn[0]),
    .highOut(highGrn),
    .lowOut (lowGrn)
  );

  nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_ylw (
    .clk    (clk),
    .rst    (rst),
    .highIn (req_ylw[1]),
    .lowIn  (req_ylw[0]),
    .highOut(highYlw),
    .lowOut (lowYlw)
  );

  nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_blu (
    .clk    (clk),
    .rst    (rst),
    .highIn (req_blu[1]),
    .lowIn  (req_blu[0]),
    .highOut(highBlu),
    .lowOut (lowBlu)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: directed and random duty/select sequences compared cycle by
// cycle against a stability-window model of PWM, decode and dead-time.
module tb_mtr_drv;

  localparam int DT  = 32;
  localparam int PER = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] duty = 11'h400;
  logic [1:0]  sel_grn = 2'b10;
  logic [1:0]  sel_ylw = 2'b10;
  logic [1:0]  sel_blu = 2'b10;
  logic        pwm_synch;
  logic        high_grn, low_grn, high_ylw, low_ylw, high_blu, low_blu;

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];

  // Reference model state: edges since reset release, latched duty, PWM level,
  // and per phase the last request plus how many cycles it has been stable.
  int         n;
  int         duty_lat;
  logic       m_pwm;
  logic [1:0] prev_req[3];
  int         run_len[3];
  int         hi_cnt[3];
  int         lo_cnt[3];
  int         synch_cnt;

  mtr_drv #(.DEAD_TIME(DT)) dut (
    .clk      (clk),
    .rst      (rst),
    .duty     (duty),
    .selGrn   (sel_grn),
    .selYlw   (sel_ylw),
    .selBlu   (sel_blu),
    .PWM_synch(pwm_synch),
    .highGrn  (high_grn),
    .lowGrn   (low_grn),
    .highYlw  (high_ylw),
    .lowYlw   (low_ylw),
    .highBlu  (high_blu),
    .lowBlu   (low_blu)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] observed();
    return {pwm_synch, high_grn, low_grn, high_ylw, low_ylw, high_blu, low_blu};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [1:0] want_req(input logic [1:0] sel, input logic pwm);
    case (sel)
      2'b10:   return {pwm, !pwm};
      2'b01:   return {!pwm, pwm};
      2'b11:   return {1'b0, pwm};
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    n        = 0;
    duty_lat = 0;
    m_pwm    = 1'b0;
    for (int p = 0; p < 3; p++) begin
      prev_req[p] = 2'b00;
      run_len[p]  = 1;
    end
    exp_q.delete();
  endtask

  // A gate pair is driven only once its request has held for DT+1 samples.
  task automatic model_edge();
    logic [1:0] sels[3];
    logic [1:0] reqs[3];
    logic [1:0] g[3];
    int         ph;
    sels[0] = sel_grn;
    sels[1] = sel_ylw;
    sels[2] = sel_blu;
    for (int p = 0; p < 3; p++) reqs[p] = want_req(sels[p], m_pwm);
    n++;
    ph = n % PER;
    if (ph == 0) duty_lat = int'(duty);
    m_pwm = (ph < duty_lat);
    for (int p = 0; p < 3; p++) begin
      if (reqs[p] == prev_req[p]) begin
        if (run_len[p] < 1000) run_len[p]++;
      end else begin
        run_len[p] = 1;
      end
      prev_req[p] = reqs[p];
      g[p] = (run_len[p] > DT) ? reqs[p] : 2'b00;
    end
    exp_q.push_back({(ph == 0), g[0], g[1], g[2]});
  endtask

  task automatic tick();
    logic [6:0] want;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 7'bxxxxxxx;
    check("gates", observed(), want);
    check("overlap", {high_grn & low_grn, high_ylw & low_ylw, high_blu & low_blu}, 0);
    synch_cnt += int'(pwm_synch);
    hi_cnt[0] += int'(high_grn);
    lo_cnt[0] += int'(low_grn);
    hi_cnt[1] += int'(high_ylw);
    lo_cnt[1] += int'(low_ylw);
    hi_cnt[2] += int'(high_blu);
    lo_cnt[2] += int'(low_blu);
  endtask

  // Counts gate-on cycles over one full period with identical selects on all phases.
  task automatic window(input string tag, input int hi_want, input int lo_want);
    synch_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      hi_cnt[p] = 0;
      lo_cnt[p] = 0;
    end
    repeat (PER) tick();
    check({tag, "_synch"}, synch_cnt, 1);
    for (int p = 0; p < 3; p++) begin
      check({tag, "_hi"}, hi_cnt[p], hi_want);
      check({tag, "_lo"}, lo_cnt[p], lo_want);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", observed(), 0);
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      check("in_reset", observed(), 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_sel(input logic [1:0] s);
    sel_grn = s;
    sel_ylw = s;
    sel_blu = s;
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // Half duty, forward on all phases.
    duty = 11'h400;
    set_sel(2'b10);
    repeat (2 * PER) tick();
    window("fwd_half", 1024 - DT, 1024 - DT);

    // Duty extremes; the full-scale value is applied mid-period.
    duty = 11'h000;
    repeat (2 * PER) tick();
    window("duty_zero", 0, PER);
    repeat ($urandom_range(100, 1900)) tick();
    duty = 11'h7FF;
    repeat (PER + 100) tick();
    window("duty_full", PER - 1 - DT, 0);

    // Green reversed mid-period.
    duty = 11'h300;
    repeat (PER + $urandom_range(200, 1500)) tick();
    sel_grn = 2'b01;
    repeat (PER) tick();

    // Braking on all phases.
    duty = 11'h600;
    set_sel(2'b11);
    repeat (2 * PER) tick();
    window("brake", 0, 1536 - DT);

    // High impedance on all phases.
    set_sel(2'b00);
    repeat (DT + 2) tick();
    window("hiz", 0, 0);

    // Random duty and select segments, with occasional boundary duties.
    for (int s = 0; s < 12; s++) begin
      if (s % 4 == 0) duty = (s % 8 == 0) ? 11'h000 : 11'h7FF;
      else            duty = 11'($urandom_range(0, 2047));
      sel_grn = 2'($urandom_range(0, 3));
      sel_ylw = 2'($urandom_range(0, 3));
      sel_blu = 2'($urandom_range(0, 3));
      repeat ($urandom_range(50, 2500)) tick();
    end

    // Mid-period reset, then the first period after release.
    duty = 11'h400;
    set_sel(2'b10);
    repeat ($urandom_range(300, 1500)) tick();
    do_reset(3);
    repeat (PER + DT + 10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
Name: mtr_drv

Overview:
Drives the power stage from the commutation block's outputs. It consumes the 11-bit duty and the per-phase 2-bit coil selects, and produces six gate signals (high/low FET per phase) with dead-time insertion. It also generates PWM_synch, which the commutation block uses to sample the hall sensors. It sits between the commutation logic and the top-level FET gate pins.

Parameters:
DEAD_TIME, 32, number of clk cycles during which both FETs of a phase are held off after any change in that phase's requested gate state (legal range 2..255).

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
duty  input  11  PWM duty, unsigned; high time = duty clk cycles per 2048-cycle period
selGrn  input  2  green coil select: 00 HIGH_Z, 01 reverse, 10 forward, 11 brake
selYlw  input  2  yellow coil select, same encoding
selBlu  input  2  blue coil select, same encoding
PWM_synch  output  1  one-cycle pulse at each PWM period start
highGrn  output  1  green high-side FET gate
lowGrn  output  1  green low-side FET gate
highYlw  output  1  yellow high-side FET gate
lowYlw  output  1  yellow low-side FET gate
highBlu  output  1  blue high-side FET gate
lowBlu  output  1  blue low-side FET gate

Behaviour:
- Reset (async, rst=1): cnt=0, duty_q=0, PWM_sig=0, PWM_synch=0, all six gate outputs 0, dead-time counters cleared and outputs held off. Outputs stay 0 for DEAD_TIME cycles after rst deasserts.
- PWM counter: cnt is 11 bits and increments every clk. It wraps from 2047 to 0 with no stall.
- Duty latch: duty_q <= duty only on the cycle cnt==2047. A mid-period duty change takes effect at the next period.
- PWM_sig (registered) <= (cnt_next < duty_q_next). duty_q=0 gives a constant 0. duty_q=2047 gives high 2047 of 2048 cycles.
- PWM_synch (registered): 1 for exactly one cycle per period, coincident with cnt==0. Period is exactly 2048 clk.
- Per-phase gate request, combinational from sel and PWM_sig:
  - 10 (forward): hi=PWM_sig, lo=~PWM_sig
  - 01 (reverse): hi=~PWM_sig, lo=PWM_sig
  - 00 (HIGH_Z): hi=0, lo=0
  - 11 (brake): hi=0, lo=PWM_sig
- Dead-time, per phase, independent. States are HOLD_OFF and PASS.
  - Any change of {hi,lo} request versus the previous cycle's request moves the phase to HOLD_OFF and clears dcnt. Both outputs are driven 0 in the next cycle.
  - HOLD_OFF: dcnt increments each cycle. When dcnt==DEAD_TIME-1, transition to PASS.
  - PASS: outputs are registered copies of the request, 1-cycle latency.
  - A new request change while in HOLD_OFF restarts dcnt from 0.
  - Safety: if the request has hi=lo=1 (illegal), both outputs are 0 regardless of state.
- Invariant: highX and lowX are never both 1 in any cycle.
- sel and duty are synchronous to clk; no resynchronisation is performed here.

Decomposition:
- Package mtr_pkg:
  - typedef enum logic [1:0] coil_sel_t {HIGH_Z=2'b00, REV_CURR=2'b01, FRWD_CURR=2'b10, BRAKING=2'b11}
  - localparam PWM_W=11
  - localparam PWM_PERIOD=2048
- Sub-module nonoverlap (clk, rst, highIn, lowIn, highOut, lowOut; parameter DEAD_TIME), instantiated once per phase.
- The top level holds the counter, duty latch, PWM_sig, PWM_synch and the sel decode.

Test Plan:
- Reset release, duty=0x400, all sel=10 -> PWM_synch every 2048 cycles. highGrn high 1024 cycles per period less dead-time edges. high and low never overlap. Gap of DEAD_TIME cycles at each PWM edge.
- duty=0 then duty=0x7FF with sel=10 -> hi constant 0, lo constant 1. Then hi high 2047/2048 cycles, with the change visible only after the next cnt wrap.
- sel Grn 10->01 mid-period -> both green gates 0 for exactly DEAD_TIME cycles, then polarity inverted. Other phases unaffected.
- All sel=11 with duty=0x600 -> all high gates 0. Low gates follow PWM_sig, 1536 of 2048 cycles minus dead-time.
- sel=00 -> all outputs of that phase stay 0 across a full period.
- Assert rst for 3 cycles mid-period -> all outputs 0 immediately (async). cnt restarts at 0. First PWM_synch occurs 2048 cycles after release. Gates stay off for at least DEAD_TIME cycles.
